// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_st_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din) + W'(1) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, start/busy/done handshake.
// Optional MULDIV_EARLY_OUT_EN: op_b_i==0 at accept bypasses CALC/FIX and completes next cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  muldiv_st_e        state, state_nxt;
  muldiv_op_e        op_in, op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [XLEN-1:0]   mcand, a_raw;
  logic              neg_res, div0;

  logic              accept, b_zero, neg_a, neg_b, neg_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, rem_try;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   fix_res;

  assign op_in  = muldiv_op_e'(funct3_i);
  assign accept = start_i && !flush_i && (state == IDLE || state == DONE);
  assign b_zero = (op_b_i == '0);
  assign neg_a  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op_a_i[XLEN-1];
  assign neg_b  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && op_b_i[XLEN-1];
  // Remainder follows the dividend sign; product and quotient follow the sign xor.
  assign neg_in = (op_in inside {OP_REM, OP_REMU}) ? neg_a : (neg_a ^ neg_b);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.din(op_a_i), .neg(neg_a), .dout(abs_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.din(op_b_i), .neg(neg_b), .dout(abs_b));

  // Multiply: acc = {partial product high, remaining multiplier bits}, shifted right each step.
  // Divide:   acc = {partial remainder, dividend bits becoming quotient bits}, shifted left.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign rem_try  = acc[2*XLEN-1:XLEN-1];
  assign div_diff = {1'b0, rem_try} - {2'b00, mcand};

  always_comb begin
    acc_step = {mul_sum, acc[XLEN-1:1]};
    if (op_q[2]) begin
      if (div_diff[XLEN+1]) acc_step = {acc[2*XLEN-2:0], 1'b0};
      else                  acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  // Products are negated across the full 2*XLEN width so the high half is correct.
  assign fix_in = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0])} : acc;

  muldiv_sign_fix #(.W(2*XLEN)) u_fix (.din(fix_in), .neg(neg_res), .dout(fix_out));

  always_comb begin
    if (op_q[2] && div0)                    fix_res = op_q[1] ? a_raw : '1;
    else if (op_q == OP_MUL || op_q[2])     fix_res = fix_out[XLEN-1:0];
    else                                    fix_res = fix_out[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE, DONE: begin
        done_o = (state == DONE);
        if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_nxt = b_zero ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        busy_o    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MUL;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      neg_res  <= 1'b0;
      div0     <= 1'b0;
      result_o <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      cnt     <= CNT_W'(XLEN - 1);
      acc     <= {{XLEN{1'b0}}, (op_in[2] ? abs_a : abs_b)};
      mcand   <= op_in[2] ? abs_b : abs_a;
      a_raw   <= op_a_i;
      neg_res <= neg_in;
      div0    <= op_in[2] && b_zero;
`ifdef MULDIV_EARLY_OUT_EN
      if (b_zero) result_o <= op_in[2] ? (op_in[1] ? op_a_i : '1) : '0;
`endif
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt - CNT_W'(1);
    end else if (state == FIX && !flush_i) begin
      result_o <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed corner cases plus random operations.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, start, flush, busy, done;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b, result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_res = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start_i(start), .funct3_i(funct3),
    .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 0;
    pu = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0) return 1;
`endif
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    step();
    start = 1'b0;
  endtask

  // Entered in cycle T+1; returns in the done cycle with lat = k where done was seen at T+k.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) busy_cyc++;
      if (done) begin lat = k; break; end
      step();
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      if (done) n++;
      step();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat, bc;
    logic [31:0] exp;
    exp = model(f, a, b);
    issue(f, a, b);
    wait_done(lat, bc);
    check_eq({tag, "_lat"}, lat, exp_lat(b));
    check_eq({tag, "_busy"}, bc, exp_lat(b) - 1);
    check_eq({tag, "_res"}, result, exp);
    last_res = exp;
    step();
  endtask

  initial begin
    int lat, bc, nd;
    logic [2:0] f;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    step(); step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_res", result, 0);
    reset = 1'b0;
    step();

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD);
    check_eq("mul_7_m3_val", last_res, 32'hFFFFFFEB);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000);
    run_op("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    run_op("mul_9_0", 3'd0, 32'd9, 32'd0);

    // Start while busy is ignored.
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    repeat (4) step();
    issue(3'd5, 32'd100, 32'd7);
    wait_done(lat, bc);
    check_eq("ign_lat", lat, XLEN + 2 - 5);
    check_eq("ign_res", result, 32'hFFFFFFEB);
    last_res = 32'hFFFFFFEB;
    step();
    count_dones(40, nd);
    check_eq("ign_nodone", nd, 0);

    // Flush mid-operation.
    issue(3'd4, 32'd1000, 32'd3);
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_busy", busy, 0);
    count_dones(40, nd);
    check_eq("flush_nodone", nd, 0);
    check_eq("flush_res", result, last_res);

    // Flush and start together: start dropped.
    flush = 1'b1;
    issue(3'd0, 32'd3, 32'd4);
    flush = 1'b0;
    check_eq("fs_busy", busy, 0);
    count_dones(40, nd);
    check_eq("fs_nodone", nd, 0);

    // Reset mid-operation.
    issue(3'd0, 32'd3, 32'd4);
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_res", result, 0);
    last_res = '0;
    step();

    // Back-to-back issue from the DONE cycle.
    issue(3'd5, 32'd100, 32'd7);
    wait_done(lat, bc);
    check_eq("b2b1_lat", lat, XLEN + 2);
    check_eq("b2b1_res", result, 32'd14);
    issue(3'd7, 32'd100, 32'd7);
    wait_done(lat, bc);
    check_eq("b2b2_lat", lat, XLEN + 2);
    check_eq("b2b2_res", result, 32'd2);
    step();

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
